mem_ctrl: RTL and testbench

- CPU-side initiator for the single-clock, registered-read block RAM (one write port, one read port, 1-cycle read latency; a read is suppressed in any cycle where we=1).
- Accepts single-word read/write requests over a ready/valid handshake and sequences the RAM ports.
- Captures read data and returns a one-cycle response.
- Provides a bulk-fill command that writes one value to every RAM word.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_ctrl_if.sv | 32 +++
 rtl/mem_ctrl_fill_counter.sv | 38 +++
 rtl/mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default geometry for the block-RAM controller.
// Holds the controller state encoding and RAM size constants.
package mem_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DEPTH          = 2**ADDR_WIDTH_DEF;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_CAP,
      RESP,
      FILL,
      FDONE
   } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response and bulk-fill signals of the RAM controller.
// The master modport is the requester; the slave modport is mem_ctrl.
interface mem_ctrl_if
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

   logic                  req;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  fill_start;
   logic [DATA_WIDTH-1:0] fill_value;
   logic                  fill_busy;
   logic                  fill_done;

   modport master (
      output req, req_we, req_addr, req_wdata, fill_start, fill_value,
      input  req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata, fill_start, fill_value,
      output req_ready, rsp_valid, rsp_rdata, fill_busy, fill_done
   );

endinterface

// File: rtl/mem_ctrl_fill_counter.sv
// Address counter for the bulk-fill sweep: load-zero, enable, and a flag
// marking the final (all-ones) address.
module mem_fill_counter #(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  load_zero_i,
   input  logic                  en_i,
   output logic [ADDR_WIDTH-1:0] count_o,
   output logic                  last_o
);

   logic [ADDR_WIDTH-1:0] count_q, count_d;

   // NOTE: defaulting count_d before the branches keeps this purely combinational (no latch).
   always_comb begin
      count_d = count_q;
      if (load_zero_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = &count_q;

endmodule

// File: rtl/mem_ctrl.sv
// CPU-side initiator for a registered-read block RAM: single-word reads and
// writes over ready/valid, plus a bulk fill that writes one value everywhere.
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  clr,
   mem_ctrl_if.slave             bus,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   state_t                state_q, state_d;
   logic                  ram_we_q, ram_we_d;
   logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  fill_busy_q, fill_busy_d;
   logic                  fill_done_q, fill_done_d;

   logic                  cnt_load;
   logic                  cnt_en;
   logic [ADDR_WIDTH-1:0] cnt_value;
   logic                  cnt_last;

   mem_fill_counter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fill_counter (
      .clk         (clk),
      .clr         (clr),
      .load_zero_i (cnt_load),
      .en_i        (cnt_en),
      .count_o     (cnt_value),
      .last_o      (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      ram_we_d    = 1'b0;
      ram_data_d  = ram_data_q;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      fill_busy_d = fill_busy_q;
      fill_done_d = 1'b0;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.fill_start) begin
               // ram_data_q doubles as the latched fill word for the whole sweep.
               state_d     = FILL;
               cnt_load    = 1'b1;
               ram_we_d    = 1'b1;
               waddr_d     = '0;
               ram_data_d  = bus.fill_value;
               fill_busy_d = 1'b1;
            end else if (bus.req && bus.req_we) begin
               state_d    = WR;
               ram_we_d   = 1'b1;
               waddr_d    = bus.req_addr;
               ram_data_d = bus.req_wdata;
            end else if (bus.req) begin
               state_d = RD_ADDR;
               raddr_d = bus.req_addr;
            end
         end
         WR: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
         end
         RD_ADDR: begin
            state_d = RD_CAP;
         end
         RD_CAP: begin
            state_d     = RESP;
            rsp_rdata_d = ram_q;
            rsp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         FILL: begin
            // The counter tracks the address being written this cycle.
            if (cnt_last) begin
               state_d     = FDONE;
               fill_busy_d = 1'b0;
               fill_done_d = 1'b1;
            end else begin
               cnt_en   = 1'b1;
               ram_we_d = 1'b1;
               waddr_d  = cnt_value + 1'b1;
            end
         end
         FDONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= IDLE;
         ram_we_q    <= 1'b0;
         ram_data_q  <= '0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         fill_busy_q <= 1'b0;
         fill_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_we_q    <= ram_we_d;
         ram_data_q  <= ram_data_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         fill_busy_q <= fill_busy_d;
         fill_done_q <= fill_done_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE) && !bus.fill_start;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.fill_busy  = fill_busy_q;
   assign bus.fill_done  = fill_done_q;
   assign ram_we         = ram_we_q;
   assign ram_data       = ram_data_q;
   assign ram_write_addr = waddr_q;
   assign ram_read_addr  = raddr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural RAM, array reference model of RAM contents,
// directed latency/fill/reset scenarios plus randomized read/write traffic.
module tb_mem_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 9;
   localparam int WORDS = 2**AW;

   logic          clk;
   logic          clr;
   logic [DW-1:0] ram_data;
   logic [AW-1:0] ram_read_addr;
   logic [AW-1:0] ram_write_addr;
   logic          ram_we;
   logic [DW-1:0] ram_q;

   mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk            (clk),
      .clr            (clr),
      .bus            (bus),
      .ram_data       (ram_data),
      .ram_read_addr  (ram_read_addr),
      .ram_write_addr (ram_write_addr),
      .ram_we         (ram_we),
      .ram_q          (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read block RAM; a read is suppressed while we=1.
   logic [DW-1:0] ram_mem [WORDS];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_write_addr] <= ram_data;
      else        ram_q <= ram_mem[ram_read_addr];
   end

   // Reference model: what every RAM word should hold.
   logic [DW-1:0] ref_mem [WORDS];
   logic [DW-1:0] last_rd;

   int n_checks = 0;
   int n_errors = 0;
   int done_total = 0;

   always @(negedge clk) if (bus.fill_done === 1'b1) done_total <= done_total + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      check("wr_c0_ready", bus.req_ready, 1);
      bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
      @(negedge clk);
      bus.req = 1'b0; bus.req_addr = ~a; bus.req_wdata = ~d;
      check("wr_c1_we", ram_we, 1);
      check("wr_c1_waddr", ram_write_addr, a);
      check("wr_c1_data", ram_data, d);
      check("wr_c1_ready", bus.req_ready, 0);
      check("wr_c1_rsp", bus.rsp_valid, 0);
      @(negedge clk);
      check("wr_c2_we", ram_we, 0);
      check("wr_c2_rsp", bus.rsp_valid, 1);
      check("wr_c2_rdata_held", bus.rsp_rdata, last_rd);
      @(negedge clk);
      check("wr_c3_ready", bus.req_ready, 1);
      check("wr_c3_rsp", bus.rsp_valid, 0);
      ref_mem[a] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      logic [DW-1:0] exp;
      exp = ref_mem[a];
      @(negedge clk);
      check("rd_c0_ready", bus.req_ready, 1);
      check("rd_c0_we", ram_we, 0);
      bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.req_wdata = $urandom;
      @(negedge clk);
      bus.req = 1'b0; bus.req_addr = ~a;
      check("rd_c1_we", ram_we, 0);
      check("rd_c1_raddr", ram_read_addr, a);
      check("rd_c1_ready", bus.req_ready, 0);
      @(negedge clk);
      check("rd_c2_we", ram_we, 0);
      check("rd_c2_rsp", bus.rsp_valid, 0);
      @(negedge clk);
      check("rd_c3_we", ram_we, 0);
      check("rd_c3_rsp", bus.rsp_valid, 1);
      check("rd_c3_rdata", bus.rsp_rdata, exp);
      @(negedge clk);
      check("rd_c4_ready", bus.req_ready, 1);
      check("rd_c4_rsp", bus.rsp_valid, 0);
      check("rd_c4_rdata_held", bus.rsp_rdata, exp);
      last_rd = exp;
   endtask

   // Full fill; optionally hold a write request pending across the whole sweep.
   task automatic do_fill(input logic [DW-1:0] v, input bit with_req,
                          input logic [AW-1:0] ra, input logic [DW-1:0] rd);
      int busy_cnt, addr_err, ready_err, cyc, done_before;
      bit done;
      logic [AW-1:0] exp_addr;
      busy_cnt = 0; addr_err = 0; ready_err = 0; cyc = 0; done = 1'b0;
      done_before = done_total;
      @(negedge clk);
      bus.fill_start = 1'b1; bus.fill_value = v;
      if (with_req) begin
         bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = ra; bus.req_wdata = rd;
      end
      #1 check("fill_start_blocks_ready", bus.req_ready, 0);
      @(negedge clk);
      bus.fill_start = 1'b0; bus.fill_value = ~v;
      while (!done && cyc < 700) begin
         if (bus.fill_busy) begin
            exp_addr = busy_cnt[AW-1:0];
            if (ram_write_addr !== exp_addr || ram_we !== 1'b1 || ram_data !== v) addr_err++;
            busy_cnt++;
         end
         if (bus.req_ready !== 1'b0) ready_err++;
         if (bus.fill_done) begin
            done = 1'b1;
            check("fdone_busy_low", bus.fill_busy, 0);
            check("fdone_we_low", ram_we, 0);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("fill_done_seen", done, 1);
      check("fill_busy_cycles", busy_cnt, WORDS);
      check("fill_write_seq_errs", addr_err, 0);
      check("fill_ready_low_errs", ready_err, 0);
      @(negedge clk);
      check("fdone_one_cycle", bus.fill_done, 0);
      check("post_fill_ready", bus.req_ready, 1);
      for (int i = 0; i < WORDS; i++) ref_mem[i] = v;
      if (with_req) begin
         @(negedge clk);
         bus.req = 1'b0;
         check("held_req_we", ram_we, 1);
         check("held_req_waddr", ram_write_addr, ra);
         check("held_req_data", ram_data, rd);
         repeat (2) @(negedge clk);
         ref_mem[ra] = rd;
      end
      check("fill_done_pulses", done_total - done_before, 1);
   endtask

   initial begin
      logic [AW-1:0] ra;
      int            done_before;
      logic [DW-1:0] v2;

      bus.req = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.fill_start = 1'b0; bus.fill_value = '0;
      last_rd = '0;
      for (int i = 0; i < WORDS; i++) begin
         ram_mem[i] = $urandom;
         ref_mem[i] = ram_mem[i];
      end

      clr = 1'b0;
      #1 clr = 1'b1;
      #1;
      check("rst_ram_we", ram_we, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_fill_busy", bus.fill_busy, 0);
      check("rst_fill_done", bus.fill_done, 0);
      check("rst_ram_data", ram_data, 0);
      check("rst_ram_waddr", ram_write_addr, 0);
      check("rst_ram_raddr", ram_read_addr, 0);
      check("rst_ready", bus.req_ready, 1);
      repeat (2) @(negedge clk);
      clr = 1'b0;

      do_write(9'h005, 32'hDEADBEEF);
      do_read(9'h005);

      for (int i = 0; i < 24; i++) begin
         ra = 9'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) do_write(ra, $urandom);
         else                           do_read(ra);
      end
      do_read(9'h1FF);

      do_fill(32'h0000_00A5, 1'b1, 9'h0AA, 32'h1234_5678);
      do_read(9'h000);
      do_read(9'h0FF);
      do_read(9'h1FF);
      do_read(9'h0AA);

      // Abort a fill with clr during fill cycle 100.
      v2 = 32'h5A5A_C3C3;
      done_before = done_total;
      @(negedge clk);
      bus.fill_start = 1'b1; bus.fill_value = v2;
      @(negedge clk);
      bus.fill_start = 1'b0;
      repeat (100) @(negedge clk);
      check("abort_pre_waddr", ram_write_addr, 100);
      clr = 1'b1;
      #1;
      check("abort_we", ram_we, 0);
      check("abort_busy", bus.fill_busy, 0);
      check("abort_done", bus.fill_done, 0);
      check("abort_waddr", ram_write_addr, 0);
      check("abort_ready", bus.req_ready, 1);
      check("abort_rdata", bus.rsp_rdata, 0);
      @(negedge clk);
      clr = 1'b0;
      last_rd = '0;
      repeat (3) @(negedge clk);
      check("abort_no_fill_done", done_total - done_before, 0);
      check("abort_busy_after", bus.fill_busy, 0);
      for (int i = 0; i < 100; i++) ref_mem[i] = v2;
      do_read(9'd0);
      do_read(9'd50);
      do_read(9'd99);
      do_read(9'd100);
      do_read(9'h0AA);
      do_read(9'd300);
      do_read(9'd511);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
